phase_sequencer: RTL and testbench

- Multi-cycle controller for the nonpipelined LEGv8 core. It sequences one instruction at a time through fetch, decode/register-read, execute, memory and writeback.
- It gates the register-file write, the PC update and the data-memory request so that each fires exactly once per instruction.
- It sits beside the decode stage: it consumes the decoded control bits and the opcode, and drives per-phase enables to the fetch, decode, execute, memory and writeback blocks.

---
 rtl/phase_sequencer.sv | 120 ++++++++++++
 tb/tb_phase_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Multi-cycle phase controller for the nonpipelined LEGv8 core.
// Walks one instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// gating the register-file write, PC update and data-memory request so
// that each fires exactly once per instruction.
module phase_sequencer #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [10:0] HALT_OPCODE = 11'h7FF,
    parameter int unsigned CNT_W       = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [10:0]      opcode,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_load,
    output logic             decode_en,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write_en,
    output logic             pc_write,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6,
        ERROR     = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             tmo_last;

    assign tmo_last = (tmo_q == TW'(TIMEOUT - 1));

    // Next-state, wait-counter and retire-counter logic
    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        retired_d = retired_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack)      state_d = DECODE;
                else if (tmo_last) state_d = ERROR;
                else               tmo_d   = tmo_q + 1'b1;
            end
            DECODE: begin
                state_d = (opcode == HALT_OPCODE) ? HALT : EXECUTE;
            end
            EXECUTE: begin
                state_d = (mem_read | mem_write) ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                if (dmem_ack)      state_d = WRITEBACK;
                else if (tmo_last) state_d = ERROR;
                else               tmo_d   = tmo_q + 1'b1;
            end
            WRITEBACK: begin
                retired_d = retired_q + 1'b1;
                state_d   = start ? FETCH : IDLE;
            end
            HALT:    state_d = HALT;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    // State, timeout counter and retired counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
        end
    end

    // Phase enables decoded from the registered state
    always_comb begin
        imem_req     = (state_q == FETCH);
        ir_load      = (state_q == FETCH) & imem_ack;
        decode_en    = (state_q == DECODE);
        alu_en       = (state_q == EXECUTE);
        dmem_req     = (state_q == MEMORY);
        // a read+write combination is treated as a write
        dmem_we      = (state_q == MEMORY) & mem_write;
        reg_write_en = (state_q == WRITEBACK) & reg_write;
        pc_write     = (state_q == WRITEBACK);
        busy         = (state_q != IDLE) && (state_q != HALT) && (state_q != ERROR);
        halted       = (state_q == HALT);
        error        = (state_q == ERROR);
        state        = state_q;
        retired      = retired_q;
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] opcode;
    logic        mem_read, mem_write, reg_write;
    logic        imem_ack, dmem_ack;
    logic        imem_req, ir_load, decode_en, alu_en, dmem_req, dmem_we;
    logic        reg_write_en, pc_write, busy, halted, error;
    logic [2:0]  state;
    logic [63:0] retired;

    int total = 0;
    int bad   = 0;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;

    phase_sequencer #(
        .TIMEOUT    (16),
        .HALT_OPCODE(11'h7FF),
        .CNT_W      (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .decode_en   (decode_en),
        .alu_en      (alu_en),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .reg_write_en(reg_write_en),
        .pc_write    (pc_write),
        .busy        (busy),
        .halted      (halted),
        .error       (error),
        .state       (state),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs all enables so one comparison checks the whole set
    function automatic logic [63:0] enables();
        return {56'd0, imem_req, decode_en, alu_en, dmem_req, dmem_we,
                reg_write_en, pc_write, ir_load};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; opcode = '0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #13;
        chk("rst_state", state, 3'd0);
        chk("rst_enables", enables(), 64'd0);
        chk("rst_flags", {busy, halted, error}, 3'b000);
        chk("rst_retired", retired, 64'd0);

        // ADD with zero-wait acks: 1,2,3,5,1
        start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        opcode = OP_ADD; reg_write = 1'b1;
        @(negedge clk); reset = 1'b1;
        tick(); chk("add_fetch", state, 3'd1);
        chk("add_fetch_en", enables(), 64'h81);   // imem_req, ir_load
        chk("add_busy", busy, 1'b1);
        tick(); chk("add_decode", state, 3'd2);
        chk("add_decode_en", enables(), 64'h40);
        tick(); chk("add_exec", state, 3'd3);
        chk("add_exec_en", enables(), 64'h20);
        tick(); chk("add_wb", state, 3'd5);
        chk("add_wb_en", enables(), 64'h06);      // reg_write_en, pc_write
        chk("add_wb_retired", retired, 64'd0);
        // LDUR, dmem_ack delayed 3 cycles
        opcode = OP_LDUR; mem_read = 1'b1; dmem_ack = 1'b0;
        tick(); chk("add_next_fetch", state, 3'd1);
        chk("add_retired", retired, 64'd1);
        tick(); chk("ld_decode", state, 3'd2);
        tick(); chk("ld_exec", state, 3'd3);
        tick(); chk("ld_mem1", state, 3'd4);
        chk("ld_mem_en", enables(), 64'h10);      // dmem_req, dmem_we=0
        tick(); chk("ld_mem2", state, 3'd4);
        tick(); chk("ld_mem3", state, 3'd4);
        tick(); chk("ld_mem4", state, 3'd4);
        chk("ld_mem4_en", enables(), 64'h10);
        dmem_ack = 1'b1;
        tick(); chk("ld_wb", state, 3'd5);
        chk("ld_wb_en", enables(), 64'h06);
        // STUR, then back to IDLE
        opcode = OP_STUR; mem_read = 1'b0; mem_write = 1'b1; reg_write = 1'b0;
        tick(); chk("ld_retired", retired, 64'd2);
        tick(); chk("st_decode", state, 3'd2);
        tick(); chk("st_exec", state, 3'd3);
        tick(); chk("st_mem", state, 3'd4);
        chk("st_mem_en", enables(), 64'h18);      // dmem_req, dmem_we
        start = 1'b0;
        tick(); chk("st_wb", state, 3'd5);
        chk("st_wb_en", enables(), 64'h02);       // pc_write only
        tick(); chk("st_idle", state, 3'd0);
        chk("st_retired", retired, 64'd3);
        chk("st_idle_busy", busy, 1'b0);

        // FETCH timeout: ERROR after exactly 16 FETCH cycles
        imem_ack = 1'b0; start = 1'b1; mem_write = 1'b0;
        tick(); chk("to_fetch1", state, 3'd1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk($sformatf("to_fetch%0d", i), state, 3'd1);
        end
        tick(); chk("to_error", state, 3'd7);
        chk("to_error_flags", {busy, halted, error}, 3'b001);
        chk("to_error_en", enables(), 64'd0);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        tick(); chk("to_error_sticky", state, 3'd7);
        chk("to_error_ack_ignored", enables(), 64'd0);

        // Ack on the 16th FETCH cycle wins over the timeout
        reset = 1'b0; imem_ack = 1'b0;
        #1; chk("rst2_state", state, 3'd0);
        chk("rst2_retired", retired, 64'd0);
        chk("rst2_error", error, 1'b0);
        @(negedge clk); reset = 1'b1;
        tick(); chk("ack16_fetch1", state, 3'd1);
        for (int i = 2; i <= 15; i++) tick();
        tick(); chk("ack16_fetch16", state, 3'd1);
        opcode = OP_ADD; mem_read = 1'b1; mem_write = 1'b1; reg_write = 1'b1;
        imem_ack = 1'b1;
        #1; chk("ack16_ir_load", ir_load, 1'b1);
        tick(); chk("ack16_decode", state, 3'd2);
        chk("ack16_no_error", error, 1'b0);
        tick(); chk("rw_exec", state, 3'd3);
        tick(); chk("rw_mem_we", {dmem_req, dmem_we}, 2'b11);
        tick(); chk("rw_wb_en", enables(), 64'h06);

        // HALT: no pc_write, not counted, start ignored
        opcode = 11'h7FF; mem_read = 1'b0; mem_write = 1'b0;
        tick(); chk("h_retired_before", retired, 64'd1);
        tick(); chk("h_decode", state, 3'd2);
        tick(); chk("h_state", state, 3'd6);
        chk("h_flags", {busy, halted, error}, 3'b010);
        chk("h_enables", enables(), 64'd0);
        start = 1'b0; tick();
        start = 1'b1; tick();
        chk("h_sticky", state, 3'd6);
        chk("h_retired", retired, 64'd1);

        // Reset during MEMORY aborts the instruction
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        opcode = OP_LDUR; mem_read = 1'b1; dmem_ack = 1'b0;
        tick(); tick(); tick(); tick();
        chk("ab_mem", state, 3'd4);
        #2 reset = 1'b0;
        #1; chk("ab_state", state, 3'd0);
        chk("ab_enables", enables(), 64'd0);
        chk("ab_retired", retired, 64'd0);
        tick(); chk("ab_no_pulse", {reg_write_en, pc_write}, 2'b00);

        // MEMORY timeout counted from MEMORY entry
        @(negedge clk); reset = 1'b1;
        tick(); tick(); tick(); tick();
        chk("mto_mem1", state, 3'd4);
        for (int i = 2; i <= 16; i++) tick();
        chk("mto_mem16", state, 3'd4);
        tick(); chk("mto_error", state, 3'd7);
        chk("mto_retired", retired, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
